// File: rtl/missionary_cannibal_engine.sv
// ---------------------------------------------------------------------------
// missionary_cannibal_engine
//
// Hardware referee for the missionaries-and-cannibals river crossing puzzle.
// N missionaries and N cannibals start on the left bank together with the
// boat. Each accepted move ferries move_m missionaries and move_c cannibals
// from whichever bank the boat is on to the opposite bank. The engine rejects
// moves that are physically impossible. It ends the game when a bank becomes
// unsafe (eaten), when the left bank is empty (solved), or when the move
// limit is reached (timeout).
//
// Parameters
//   N          party size per group (1..7)
//   CAP        boat capacity (1..N)
//   MAX_MOVES  accepted-move limit before timeout (1..255)
//
// Ports
//   clock            system clock, rising-edge active
//   reset_n          asynchronous active-low reset
//   start            one-cycle request to (re)load the puzzle and enter PLAY
//   move_valid       a move is presented on move_m / move_c
//   move_m           missionaries carried by the presented move
//   move_c           cannibals carried by the presented move
//   move_ready       high when a presented move would be taken this cycle
//   missionary_left  missionaries currently on the left bank
//   cannibal_left    cannibals currently on the left bank
//   boat_left        1 when the boat is on the left bank
//   finish           000 running/idle, 001 solved, 010 eaten, 100 timeout
//   move_count       number of accepted legal moves in this game
//   reject           one-cycle pulse after a structurally illegal move
// ---------------------------------------------------------------------------
module missionary_cannibal_engine #(
  parameter int N         = 3,
  parameter int CAP       = 2,
  parameter int MAX_MOVES = 255,
  localparam int W        = $clog2(N + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         move_valid,
  input  logic [W-1:0] move_m,
  input  logic [W-1:0] move_c,
  output logic         move_ready,
  output logic [W-1:0] missionary_left,
  output logic [W-1:0] cannibal_left,
  output logic         boat_left,
  output logic [2:0]   finish,
  output logic [7:0]   move_count,
  output logic         reject
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SOLVED,
    FAILED
  } state_t;

  localparam logic [W-1:0] N_W       = W'(N);
  localparam logic [W:0]   CAP_W     = (W + 1)'(CAP);
  localparam logic [7:0]   MAX_W     = 8'(MAX_MOVES);

  localparam logic [2:0]   FIN_RUN     = 3'b000;
  localparam logic [2:0]   FIN_SOLVED  = 3'b001;
  localparam logic [2:0]   FIN_EATEN   = 3'b010;
  localparam logic [2:0]   FIN_TIMEOUT = 3'b100;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   missionary_nxt;
  logic [W-1:0]   cannibal_nxt;
  logic           boat_nxt;
  logic [2:0]     finish_nxt;
  logic [7:0]     count_nxt;
  logic           reject_nxt;

  logic           accept;
  logic [W-1:0]   right_m;
  logic [W-1:0]   right_c;
  logic [W-1:0]   src_m;
  logic [W-1:0]   src_c;
  logic [W:0]     load_sum;
  logic           legal;
  logic [W-1:0]   post_ml;
  logic [W-1:0]   post_cl;
  logic [W-1:0]   post_mr;
  logic [W-1:0]   post_cr;
  logic           left_safe;
  logic           right_safe;
  logic [7:0]     count_inc;

  // Start always wins over a move in the same cycle, so the handshake is
  // suppressed while start is high.
  assign move_ready = (state == PLAY) && !start;
  assign accept     = move_valid && move_ready;

  // The right bank is never stored; it is the complement of the left bank.
  assign right_m = N_W - missionary_left;
  assign right_c = N_W - cannibal_left;
  assign src_m   = boat_left ? missionary_left : right_m;
  assign src_c   = boat_left ? cannibal_left   : right_c;

  // The load is summed one bit wider so that two large counts cannot wrap
  // into an apparently legal value.
  assign load_sum = {1'b0, move_m} + {1'b0, move_c};
  assign legal    = (load_sum != '0) && (load_sum <= CAP_W) &&
                    (src_m >= move_m) && (src_c >= move_c);

  // Post-move bank contents. These values are only committed when the move
  // is legal, which guarantees the subtraction cannot underflow.
  assign post_ml = boat_left ? (missionary_left - move_m) : (missionary_left + move_m);
  assign post_cl = boat_left ? (cannibal_left   - move_c) : (cannibal_left   + move_c);
  assign post_mr = N_W - post_ml;
  assign post_cr = N_W - post_cl;

  // A bank is safe when missionaries are absent or not outnumbered.
  assign left_safe  = (post_ml == '0) || (post_ml >= post_cl);
  assign right_safe = (post_mr == '0) || (post_mr >= post_cr);

  // MAX_MOVES ends the game before the counter could ever wrap.
  assign count_inc = move_count + 8'd1;

  // State and datapath registers. Reset restores the loaded-puzzle values
  // but parks the engine in IDLE until a start arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      missionary_left <= N_W;
      cannibal_left   <= N_W;
      boat_left       <= 1'b1;
      finish          <= FIN_RUN;
      move_count      <= 8'd0;
      reject          <= 1'b0;
    end else begin
      state           <= state_nxt;
      missionary_left <= missionary_nxt;
      cannibal_left   <= cannibal_nxt;
      boat_left       <= boat_nxt;
      finish          <= finish_nxt;
      move_count      <= count_nxt;
      reject          <= reject_nxt;
    end
  end

  // Next-state logic. Everything holds by default and reject clears itself,
  // which makes reject a single-cycle pulse. When a legal move is accepted,
  // the end-of-game checks are ordered eaten, then solved, then timeout.
  always_comb begin
    state_nxt      = state;
    missionary_nxt = missionary_left;
    cannibal_nxt   = cannibal_left;
    boat_nxt       = boat_left;
    finish_nxt     = finish;
    count_nxt      = move_count;
    reject_nxt     = 1'b0;

    if (start) begin
      state_nxt      = PLAY;
      missionary_nxt = N_W;
      cannibal_nxt   = N_W;
      boat_nxt       = 1'b1;
      finish_nxt     = FIN_RUN;
      count_nxt      = 8'd0;
    end else if (accept) begin
      if (!legal) begin
        reject_nxt = 1'b1;
      end else begin
        missionary_nxt = post_ml;
        cannibal_nxt   = post_cl;
        boat_nxt       = !boat_left;
        count_nxt      = count_inc;
        if (!(left_safe && right_safe)) begin
          finish_nxt = FIN_EATEN;
          state_nxt  = FAILED;
        end else if ((post_ml == '0) && (post_cl == '0)) begin
          finish_nxt = FIN_SOLVED;
          state_nxt  = SOLVED;
        end else if (count_inc == MAX_W) begin
          finish_nxt = FIN_TIMEOUT;
          state_nxt  = FAILED;
        end
      end
    end
  end

endmodule

// File: tb/tb_missionary_cannibal_engine.sv
// ---------------------------------------------------------------------------
// tb_missionary_cannibal_engine
//
// Directed testbench for missionary_cannibal_engine. It has two instances:
//   dut    default parameters (N=3, CAP=2, MAX_MOVES=255)
//   dut_t  MAX_MOVES=4, used to exercise the timeout path
// Both instances share the same stimulus. Each stimulus step pushes the
// hand-computed expected outputs into a scoreboard queue. A monitor pops the
// queue on the falling clock edge and compares the entry against the
// instance selected in that entry.
// ---------------------------------------------------------------------------
module tb_missionary_cannibal_engine;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       move_valid;
  logic [1:0] move_m;
  logic [1:0] move_c;

  logic       a_ready, a_boat, a_rej;
  logic [1:0] a_ml, a_cl;
  logic [2:0] a_fin;
  logic [7:0] a_cnt;

  logic       t_ready, t_boat, t_rej;
  logic [1:0] t_ml, t_cl;
  logic [2:0] t_fin;
  logic [7:0] t_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;
    logic [1:0] ml;
    logic [1:0] cl;
    logic       boat;
    logic [2:0] fin;
    logic [7:0] cnt;
    logic       rej;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  missionary_cannibal_engine #(.N(3), .CAP(2), .MAX_MOVES(255)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .move_valid(move_valid),
    .move_m(move_m), .move_c(move_c), .move_ready(a_ready),
    .missionary_left(a_ml), .cannibal_left(a_cl), .boat_left(a_boat),
    .finish(a_fin), .move_count(a_cnt), .reject(a_rej)
  );

  missionary_cannibal_engine #(.N(3), .CAP(2), .MAX_MOVES(4)) dut_t (
    .clock(clock), .reset_n(reset_n), .start(start), .move_valid(move_valid),
    .move_m(move_m), .move_c(move_c), .move_ready(t_ready),
    .missionary_left(t_ml), .cannibal_left(t_cl), .boat_left(t_boat),
    .finish(t_fin), .move_count(t_cnt), .reject(t_rej)
  );

  // Single comparison point shared by the monitor and the direct checks.
  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit sel, input int ml, input int cl, input bit boat,
                              input int fin, input int cnt, input bit rej, input bit rdy,
                              input string tag);
    exp_t e;
    e.sel  = sel;
    e.ml   = 2'(ml);
    e.cl   = 2'(cl);
    e.boat = boat;
    e.fin  = 3'(fin);
    e.cnt  = 8'(cnt);
    e.rej  = rej;
    e.rdy  = rdy;
    e.tag  = tag;
    return e;
  endfunction

  // Compare one scoreboard entry against the instance it names.
  task automatic check_snapshot(input exp_t e);
    check_output({e.tag, ".ml"},    8'(e.sel ? t_ml    : a_ml),    8'(e.ml));
    check_output({e.tag, ".cl"},    8'(e.sel ? t_cl    : a_cl),    8'(e.cl));
    check_output({e.tag, ".boat"},  8'(e.sel ? t_boat  : a_boat),  8'(e.boat));
    check_output({e.tag, ".fin"},   8'(e.sel ? t_fin   : a_fin),   8'(e.fin));
    check_output({e.tag, ".cnt"},   e.sel ? t_cnt : a_cnt,         e.cnt);
    check_output({e.tag, ".rej"},   8'(e.sel ? t_rej   : a_rej),   8'(e.rej));
    check_output({e.tag, ".ready"}, 8'(e.sel ? t_ready : a_ready), 8'(e.rdy));
  endtask

  // Direct check of the reset values of the default instance (no clock edge involved).
  task automatic check_reset_values(input string tag);
    check_output({tag, ".ml"},    8'(a_ml),    8'd3);
    check_output({tag, ".cl"},    8'(a_cl),    8'd3);
    check_output({tag, ".boat"},  8'(a_boat),  8'd1);
    check_output({tag, ".fin"},   8'(a_fin),   8'd0);
    check_output({tag, ".cnt"},   a_cnt,       8'd0);
    check_output({tag, ".rej"},   8'(a_rej),   8'd0);
    check_output({tag, ".ready"}, 8'(a_ready), 8'd0);
  endtask

  // Drive one cycle of stimulus after the falling edge, then return the
  // inputs to idle after the rising edge and queue the expected outputs.
  task automatic apply_stimulus(input bit st, input bit mv, input int m, input int c,
                                input exp_t e);
    @(negedge clock);
    #1;
    start      = st;
    move_valid = mv;
    move_m     = 2'(m);
    move_c     = 2'(c);
    if (st) begin
      #1;
      check_output({e.tag, ".ready_with_start"}, 8'(e.sel ? t_ready : a_ready), 8'd0);
    end
    @(posedge clock);
    #1;
    start      = 1'b0;
    move_valid = 1'b0;
    move_m     = 2'd0;
    move_c     = 2'd0;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: the falling edge is where registered outputs are stable.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      check_snapshot(sb.pop_front());
    end
  end

  // Watchdog: guarantees the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Known 11-move solution and the left bank after each move.
  int sol_m[11]  = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
  int sol_c[11]  = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};
  int exp_ml[11] = '{3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
  int exp_cl[11] = '{1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    move_valid = 1'b0;
    move_m     = 2'd0;
    move_c     = 2'd0;

    repeat (2) @(negedge clock);
    check_reset_values("reset");
    #1;
    reset_n = 1'b1;

    // Moves in IDLE are ignored without a reject.
    apply_stimulus(0, 1, 0, 2, mk(0, 3, 3, 1, 0, 0, 0, 0, "idle_move"));
    apply_stimulus(1, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "start"));

    // The full solution ends in SOLVED after the last move.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(0, 1, sol_m[i], sol_c[i],
                     mk(0, exp_ml[i], exp_cl[i], bit'((i + 1) % 2 == 0),
                        (i == 10) ? 1 : 0, i + 1, 0, (i == 10) ? 0 : 1,
                        $sformatf("sol%0d", i + 1)));
    end
    apply_stimulus(0, 1, 0, 1, mk(0, 0, 0, 0, 1, 11, 0, 0, "solved_hold"));

    // Restart from SOLVED.
    apply_stimulus(1, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "restart_solved"));

    // A lone missionary leaves three cannibals with two missionaries: eaten.
    apply_stimulus(0, 1, 1, 0, mk(0, 2, 3, 0, 2, 1, 0, 0, "eaten"));
    apply_stimulus(0, 1, 0, 1, mk(0, 2, 3, 0, 2, 1, 0, 0, "failed_hold"));

    // Structural rejects: over capacity, empty boat, and a source bank shortfall.
    apply_stimulus(1, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "restart_failed"));
    apply_stimulus(0, 1, 2, 1, mk(0, 3, 3, 1, 0, 0, 1, 1, "rej_overcap"));
    apply_stimulus(0, 1, 0, 0, mk(0, 3, 3, 1, 0, 0, 1, 1, "rej_empty"));
    apply_stimulus(0, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "rej_clears"));
    apply_stimulus(0, 1, 0, 2, mk(0, 3, 1, 0, 0, 1, 0, 1, "c2_out"));
    apply_stimulus(0, 1, 1, 0, mk(0, 3, 1, 0, 0, 1, 1, 1, "rej_source"));

    // The MAX_MOVES=4 instance times out on the fourth shuttle move.
    apply_stimulus(1, 0, 0, 0, mk(1, 3, 3, 1, 0, 0, 0, 1, "to_start"));
    apply_stimulus(0, 1, 0, 1, mk(1, 3, 2, 0, 0, 1, 0, 1, "to_m1"));
    apply_stimulus(0, 1, 0, 1, mk(1, 3, 3, 1, 0, 2, 0, 1, "to_m2"));
    apply_stimulus(0, 1, 0, 1, mk(1, 3, 2, 0, 0, 3, 0, 1, "to_m3"));
    apply_stimulus(0, 1, 0, 1, mk(1, 3, 3, 1, 4, 4, 0, 0, "to_m4"));

    // Reset dropped between edges in the middle of a game.
    apply_stimulus(1, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "pre_reset_start"));
    apply_stimulus(0, 1, 0, 2, mk(0, 3, 1, 0, 0, 1, 0, 1, "pre_reset_move"));
    @(negedge clock);
    #2;
    move_valid = 1'b1;
    move_m     = 2'd0;
    move_c     = 2'd1;
    reset_n    = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clock);
    #1;
    check_reset_values("reset_held_edge");
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Start and a move together: start wins, no move and no reject.
    apply_stimulus(1, 1, 0, 1, mk(0, 3, 3, 1, 0, 0, 0, 1, "start_and_move"));
    apply_stimulus(0, 0, 0, 0, mk(0, 3, 3, 1, 0, 0, 0, 1, "after_start_idle"));
    apply_stimulus(0, 1, 1, 1, mk(0, 2, 2, 0, 0, 1, 0, 1, "live_after_reset"));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: got %0d pending, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
